// File: rtl/alu_cmd_seq.sv
// Purpose: command sequencer for the 32-bit combinational ALU; owns an 8x32 register file and drives the ALU operands.
// Latency: accept at edge N -> res_valid after edge N+2; with res_ready held high, the next accept is at edge N+4.
// Backpressure: cmd_ready is high only in IDLE with no load pending; results are held stable until res_ready.
module alu_cmd_seq #(
    parameter int DW       = 32,
    parameter int RF_DEPTH = 8,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [AW-1:0] res_rd,
    output logic          res_zero,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_NEG = 3'd7;

    state_t        state_q;
    state_t        state_d;
    logic          cmd_acc;
    logic [DW-1:0] rf [RF_DEPTH];
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; a load in IDLE blocks command acceptance.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        cmd_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n & ~ld_en;
                cmd_acc   = cmd_ready & cmd_valid;
                if (cmd_acc) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT:  state_d = RESP;
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Latch the accepted command fields for the rest of the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
        end else if (cmd_acc) begin
            op_q <= cmd_op;
            rd_q <= cmd_rd;
            rs_q <= cmd_rs;
            rt_q <= cmd_rt;
        end
    end

    // Register file writes: direct loads in IDLE, ALU write-back in CAPT; r0 is never written so it reads as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (state_q == IDLE && ld_en) begin
            if (ld_addr != '0) begin
                rf[ld_addr] <= ld_data;
            end
        end else if (state_q == CAPT) begin
            if (rd_q != '0) begin
                rf[rd_q] <= alu_out;
            end
        end
    end

    // ALU operand drive: operands read in ISSUE (after any prior write-back), cleared again in CAPT.
    // NEG is issued as 0 - rs so the ALU itself never receives opcode 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (state_q == ISSUE) begin
            if (op_q == OP_NEG) begin
                alu_a  <= '0;
                alu_b  <= rf[rs_q];
                alu_op <= OP_SUB;
            end else begin
                alu_a  <= rf[rs_q];
                alu_b  <= rf[rt_q];
                alu_op <= op_q;
            end
        end else if (state_q == CAPT) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end
    end

    // Result channel: capture in CAPT, hold through RESP until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_zero  <= 1'b0;
        end else if (state_q == CAPT) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_rd    <= rd_q;
            res_zero  <= (alu_out == '0);
        end else if (state_q == RESP && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
module tb_alu_cmd_seq;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [AW-1:0] cmd_rt;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_out;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_rd;
    logic          res_zero;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int seen7 = 0;

    // reference register file
    logic [DW-1:0] ref_rf [8];

    // observations from run_cmd
    logic [DW-1:0] obs_a, obs_b, obs_data;
    logic [2:0]    obs_op;
    logic [AW-1:0] obs_rd;
    logic          obs_rv, obs_zero, obs_stable;
    int            obs_wait, obs_acc_cyc;

    alu_cmd_seq #(.DW(DW), .RF_DEPTH(8), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_rd    (res_rd),
        .res_zero  (res_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // opcode 7 must never reach the ALU
    always @(negedge clk) if (alu_op === 3'd7) seen7 <= seen7 + 1;

    // combinational ALU (op6 chosen as a left shift for this bench)
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a << b[4:0];
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_a, alu_b, alu_op);

    // architectural reference: what the command does to the register file
    task automatic ref_exec(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rt, output logic [DW-1:0] r);
        logic [DW-1:0] a, b;
        a = ref_rf[rs];
        b = ref_rf[rt];
        case (op)
            3'd0: r = '0;
            3'd1: r = a + b;
            3'd2: r = a - b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = a << b[4:0];
            default: r = 32'd0 - a;
        endcase
        if (rd != 0) ref_rf[rd] = r;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    endtask

    task automatic do_ld(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
        if (addr != 0) ref_rf[addr] = data;
    endtask

    // Drive one command through the whole sequence, recording what is seen in CAPT and RESP.
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                           input logic [AW-1:0] rt, input int hold);
        int n;
        obs_stable = 1'b1;
        res_ready  = 1'b0;
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_valid = 1'b1;
        n = 0;
        #1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        obs_wait    = n;
        obs_acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        obs_a = alu_a; obs_b = alu_b; obs_op = alu_op;
        @(negedge clk);
        obs_rv = res_valid; obs_data = res_data; obs_rd = res_rd; obs_zero = res_zero;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_data !== obs_data || res_valid !== 1'b1 || res_rd !== obs_rd || cmd_ready !== 1'b0)
                obs_stable = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== '0) begin n_bad++; $display("FAIL rst_alu: got %h %h %h want 0", alu_a, alu_b, alu_op); end
        n_cmp++; if ({res_data, res_rd, res_zero} !== '0) begin n_bad++; $display("FAIL rst_res: got %h %h %b want 0", res_data, res_rd, res_zero); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        rst_n = 1'b1;
        ref_clear();
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_cmd_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [DW-1:0] e;
        do_ld(3'd1, 32'd5);
        do_ld(3'd2, 32'd3);
        ref_exec(3'd1, 3'd3, 3'd1, 3'd2, e);
        run_cmd(3'd1, 3'd3, 3'd1, 3'd2, 0);
        n_cmp++; if (obs_op !== 3'd1 || obs_a !== 32'd5 || obs_b !== 32'd3) begin n_bad++; $display("FAIL add_capt: got op=%0d a=%0d b=%0d want 1 5 3", obs_op, obs_a, obs_b); end
        n_cmp++; if (obs_rv !== 1'b1) begin n_bad++; $display("FAIL add_latency: res_valid=%b want 1 two edges after accept", obs_rv); end
        n_cmp++; if (obs_data !== 32'd8 || e !== 32'd8) begin n_bad++; $display("FAIL add_data: got %0d want 8", obs_data); end
        n_cmp++; if (obs_rd !== 3'd3 || obs_zero !== 1'b0) begin n_bad++; $display("FAIL add_rd_zero: got rd=%0d z=%b want 3 0", obs_rd, obs_zero); end
        // r3 readback through an ADD with r0
        ref_exec(3'd1, 3'd7, 3'd3, 3'd0, e);
        run_cmd(3'd1, 3'd7, 3'd3, 3'd0, 0);
        n_cmp++; if (obs_data !== 32'd8) begin n_bad++; $display("FAIL add_r3_wb: got %0d want 8", obs_data); end
    endtask

    task automatic test_neg();
        logic [DW-1:0] e;
        do_ld(3'd1, 32'h0000_000F);
        ref_exec(3'd7, 3'd4, 3'd1, 3'd0, e);
        run_cmd(3'd7, 3'd4, 3'd1, 3'd0, 0);
        n_cmp++; if (obs_op !== 3'd2 || obs_a !== 32'd0 || obs_b !== 32'h0000_000F) begin n_bad++; $display("FAIL neg_capt: got op=%0d a=%h b=%h want 2 0 f", obs_op, obs_a, obs_b); end
        n_cmp++; if (obs_data !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL neg_data: got %h want fffffff1", obs_data); end
    endtask

    task automatic test_zero_r0();
        logic [DW-1:0] e;
        do_ld(3'd1, 32'd7);
        ref_exec(3'd2, 3'd5, 3'd1, 3'd1, e);
        run_cmd(3'd2, 3'd5, 3'd1, 3'd1, 0);
        n_cmp++; if (obs_data !== 32'd0 || obs_zero !== 1'b1) begin n_bad++; $display("FAIL sub_zero: got %0d z=%b want 0 1", obs_data, obs_zero); end
        ref_exec(3'd1, 3'd0, 3'd1, 3'd1, e);
        run_cmd(3'd1, 3'd0, 3'd1, 3'd1, 0);
        n_cmp++; if (obs_data !== 32'd14 || obs_rd !== 3'd0) begin n_bad++; $display("FAIL add_rd0: got %0d rd=%0d want 14 0", obs_data, obs_rd); end
        do_ld(3'd0, 32'hDEAD_BEEF);
        ref_exec(3'd1, 3'd2, 3'd0, 3'd1, e);
        run_cmd(3'd1, 3'd2, 3'd0, 3'd1, 0);
        n_cmp++; if (obs_a !== 32'd0 || obs_data !== 32'd7) begin n_bad++; $display("FAIL r0_read: got a=%h data=%0d want 0 7", obs_a, obs_data); end
        ref_exec(3'd0, 3'd6, 3'd1, 3'd1, e);
        run_cmd(3'd0, 3'd6, 3'd1, 3'd1, 0);
        n_cmp++; if (obs_data !== 32'd0 || obs_zero !== 1'b1 || obs_rd !== 3'd6) begin n_bad++; $display("FAIL nop: got %h z=%b rd=%0d want 0 1 6", obs_data, obs_zero, obs_rd); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e;
        ref_exec(3'd5, 3'd3, 3'd1, 3'd2, e);
        run_cmd(3'd5, 3'd3, 3'd1, 3'd2, 5);
        n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL hold_stable: stable=%b want 1", obs_stable); end
        n_cmp++; if (obs_data !== e) begin n_bad++; $display("FAIL hold_data: got %h want %h", obs_data, e); end
        // pending command during a held response: blocked, then taken immediately in IDLE
        ref_exec(3'd4, 3'd2, 3'd3, 3'd1, e);
        cmd_op = 3'd4; cmd_rd = 3'd2; cmd_rs = 3'd3; cmd_rt = 3'd1; cmd_valid = 1'b1;
        // the previous run_cmd returned in IDLE, so this one is accepted at once
        run_cmd(3'd4, 3'd2, 3'd3, 3'd1, 5);
        n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL hold2_stable: stable=%b want 1", obs_stable); end
        n_cmp++; if (obs_wait !== 0 || obs_data !== e) begin n_bad++; $display("FAIL hold2_data: wait=%0d got %h want 0 %h", obs_wait, obs_data, e); end
    endtask

    task automatic test_ld_priority();
        logic [DW-1:0] e;
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 32'h1234_5678;
        cmd_op = 3'd1; cmd_rd = 3'd6; cmd_rs = 3'd5; cmd_rt = 3'd5; cmd_valid = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ld_blocks_cmd: cmd_ready=%b want 0", cmd_ready); end
        @(negedge clk);
        ld_en = 1'b0;
        ref_rf[5] = 32'h1234_5678;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ld_no_accept: busy=%b want 0", busy); end
        ref_exec(3'd1, 3'd6, 3'd5, 3'd5, e);
        run_cmd(3'd1, 3'd6, 3'd5, 3'd5, 0);
        n_cmp++; if (obs_wait !== 0 || obs_data !== e) begin n_bad++; $display("FAIL ld_then_cmd: wait=%0d got %h want 0 %h", obs_wait, obs_data, e); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int c0;
        do_ld(3'd1, 32'd100);
        ref_exec(3'd1, 3'd2, 3'd1, 3'd1, e);
        run_cmd(3'd1, 3'd2, 3'd1, 3'd1, 0);
        c0 = obs_acc_cyc;
        ref_exec(3'd2, 3'd3, 3'd2, 3'd1, e);
        run_cmd(3'd2, 3'd3, 3'd2, 3'd1, 0);
        n_cmp++; if (obs_acc_cyc - c0 !== 4) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 4", obs_acc_cyc - c0); end
        n_cmp++; if (obs_data !== 32'd100 || e !== 32'd100) begin n_bad++; $display("FAIL b2b_dependent: got %0d want 100", obs_data); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        do_ld(3'd1, 32'd9);
        do_ld(3'd2, 32'd4);
        cmd_op = 3'd1; cmd_rd = 3'd6; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_valid = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_accept: cmd_ready=%b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (alu_op !== 3'd1 || alu_a !== 32'd9) begin n_bad++; $display("FAIL mid_capt: op=%0d a=%0d want 1 9", alu_op, alu_a); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0 || alu_op !== 3'd0 || alu_a !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst: rv=%b op=%0d a=%h busy=%b want 0 0 0 0", res_valid, alu_op, alu_a, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_clear();
        ref_exec(3'd1, 3'd7, 3'd6, 3'd0, e);
        run_cmd(3'd1, 3'd7, 3'd6, 3'd0, 0);
        n_cmp++; if (obs_data !== 32'd0) begin n_bad++; $display("FAIL mid_r6: got %h want 0", obs_data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] e, d;
        logic [2:0] op;
        logic [AW-1:0] rd, rs, rt;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 2));
                do_ld(AW'($urandom_range(0, 7)), d);
            end
            op = 3'($urandom_range(0, 7));
            rd = AW'($urandom_range(0, 7));
            rs = AW'($urandom_range(0, 7));
            rt = AW'($urandom_range(0, 7));
            ref_exec(op, rd, rs, rt, e);
            run_cmd(op, rd, rs, rt, $urandom_range(0, 3));
            n_cmp++; if (obs_data !== e || obs_rd !== rd || obs_zero !== (e == 0) || obs_rv !== 1'b1 || obs_stable !== 1'b1)
                begin n_bad++; $display("FAIL rand_%0d op=%0d: got %h rd=%0d z=%b rv=%b st=%b want %h %0d %b 1 1", k, op, obs_data, obs_rd, obs_zero, obs_rv, obs_stable, e, rd, (e == 0)); end
            n_cmp++; if (obs_op !== ((op == 3'd7) ? 3'd2 : op))
                begin n_bad++; $display("FAIL rand_op_%0d: got %0d want %0d", k, obs_op, (op == 3'd7) ? 3'd2 : op); end
        end
    endtask

    initial begin
        ld_en = 0; ld_addr = 0; ld_data = 0;
        cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0;
        res_ready = 0;
        test_reset();
        test_add();
        test_neg();
        test_zero_r0();
        test_backpressure();
        test_ld_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        n_cmp++; if (seen7 !== 0) begin n_bad++; $display("FAIL alu_op7_seen: got %0d want 0", seen7); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
